// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default mantissa width,
// derived significand/product widths, GRS bit positions and FSM states.
package fp_pkg;

  // Stored mantissa width of an IEEE-754 single-precision value
  localparam int BIT_WIDTH = 23;
  // Significand width including the hidden bit
  localparam int SIG_W     = BIT_WIDTH + 1;
  // Full product width of two significands
  localparam int PROD_W    = 2 * SIG_W;

  // Bit positions inside the {guard, round, sticky} field
  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mantissa_multiplier_if.sv
// Operand/result handshake bundle of the mantissa multiplier.
// master = producer of operands and consumer of results; slave = multiplier.
interface mantissa_multiplier_if #(
  parameter int BIT_WIDTH = fp_pkg::BIT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in0;
  logic [31:0]          in1;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_mantissa;
  logic                 out_exp_inc;
  logic [2:0]           out_grs;

  modport master (
    output in_valid, in0, in1, out_ready,
    input  in_ready, out_valid, out_mantissa, out_exp_inc, out_grs
  );

  modport slave (
    input  in_valid, in0, in1, out_ready,
    output in_ready, out_valid, out_mantissa, out_exp_inc, out_grs
  );

endinterface

// File: rtl/mantissa_multiplier_normalizer.sv
// Combinational normalizer: turns a raw significand product in [1,4) into a
// hidden-bit-stripped mantissa, an exponent-increment flag and GRS bits.
module mantissa_normalizer
  import fp_pkg::*;
#(
  parameter int BIT_WIDTH = fp_pkg::BIT_WIDTH
) (
  input  logic [2*BIT_WIDTH+1:0] i_prod,
  output logic [BIT_WIDTH-1:0]   o_mantissa,
  output logic                   o_exp_inc,
  output logic [2:0]             o_grs
);

  localparam int L_PROD_W = 2 * BIT_WIDTH + 2;

  // Product with its leading one aligned to the top; the leading one itself
  // is the hidden bit and is dropped, so only PROD_W-1 bits remain.
  logic [L_PROD_W-2:0] w_norm;

  // Shift left by one when the product is below 2.0 so both cases share fields
  always_comb begin
    w_norm = '0;
    if (i_prod[L_PROD_W-1]) begin
      w_norm = i_prod[L_PROD_W-2:0];
    end else begin
      w_norm = {i_prod[L_PROD_W-3:0], 1'b0};
    end
  end

  assign o_exp_inc  = i_prod[L_PROD_W-1];
  assign o_mantissa = w_norm[L_PROD_W-2 -: BIT_WIDTH];

  // Guard and round are the two bits right below the kept mantissa,
  // sticky collects everything further down.
  assign o_grs[GRS_G] = w_norm[BIT_WIDTH];
  assign o_grs[GRS_R] = w_norm[BIT_WIDTH-1];
  assign o_grs[GRS_S] = |w_norm[BIT_WIDTH-2:0];

endmodule

// File: rtl/mantissa_multiplier.sv
// Sequential shift-and-add significand multiplier: one partial-product
// step per cycle over BIT_WIDTH+1 cycles, result held until consumed.
module mantissa_multiplier
  import fp_pkg::*;
#(
  parameter int BIT_WIDTH = fp_pkg::BIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mantissa_multiplier_if.slave  bus
);

  localparam int L_SIG_W  = BIT_WIDTH + 1;
  localparam int L_PROD_W = 2 * L_SIG_W;
  localparam int CNT_W    = $clog2(BIT_WIDTH + 1);

  state_t r_state;
  state_t w_state_next;

  logic [L_SIG_W-1:0]   r_m;
  logic [L_SIG_W-1:0]   r_a;
  logic [L_SIG_W-1:0]   r_q;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_WIDTH-1:0] r_mantissa;
  logic                 r_exp_inc;
  logic [2:0]           r_grs;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic [L_SIG_W:0]     w_sum;
  logic                 w_carry;
  logic [L_SIG_W-1:0]   w_a_next;
  logic [L_SIG_W-1:0]   w_q_next;
  logic [L_PROD_W-1:0]  w_prod_next;
  logic [BIT_WIDTH-1:0] w_norm_mantissa;
  logic                 w_norm_exp_inc;
  logic [2:0]           w_norm_grs;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt == CNT_W'(BIT_WIDTH));

  // One shift-and-add step. The carry out of the add is only needed for the
  // cycle it is produced in: it shifts straight into the top of A, so the
  // C register collapses to this wire.
  assign w_sum       = {1'b0, r_a} + {1'b0, (r_q[0] ? r_m : '0)};
  assign w_carry     = w_sum[L_SIG_W];
  assign w_a_next    = {w_carry, w_sum[L_SIG_W-1:1]};
  assign w_q_next    = {w_sum[0], r_q[L_SIG_W-1:1]};
  assign w_prod_next = {w_a_next, w_q_next};

  // The normalizer sees the product as it will stand after this step, so the
  // result registers can load on the final CALC edge.
  mantissa_normalizer #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_normalizer (
    .i_prod     (w_prod_next),
    .o_mantissa (w_norm_mantissa),
    .o_exp_inc  (w_norm_exp_inc),
    .o_grs      (w_norm_grs)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = CALC;
      CALC:    if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded directly from the state
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, iteration datapath, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_a        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_mantissa <= '0;
      r_exp_inc  <= 1'b0;
      r_grs      <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (w_accept) begin
          // Operands are always treated as normal numbers: hidden bit forced
          r_m   <= {1'b1, bus.in0[BIT_WIDTH-1:0]};
          r_q   <= {1'b1, bus.in1[BIT_WIDTH-1:0]};
          r_a   <= '0;
          r_cnt <= '0;
        end
      end else if (r_state == CALC) begin
        r_a   <= w_a_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_mantissa <= w_norm_mantissa;
          r_exp_inc  <= w_norm_exp_inc;
          r_grs      <= w_norm_grs;
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_mantissa = r_mantissa;
  assign bus.out_exp_inc  = r_exp_inc;
  assign bus.out_grs      = r_grs;

endmodule

// File: tb/tb_mantissa_multiplier.sv
// Self-checking bench for mantissa_multiplier: directed vectors, random
// operands against an arithmetic reference, backpressure, turnaround and
// asynchronous reset in the middle of a calculation.
module tb_mantissa_multiplier;

  localparam int EXP_LAT = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mantissa_multiplier_if bus ();

  mantissa_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: exact integer product of the two significands, then split
  // into fraction / guard / round / sticky by plain division and remainder.
  function automatic void model(input logic [22:0] a, input logic [22:0] b,
                                output logic [22:0] mant, output logic inc,
                                output logic [2:0] grs);
    longint unsigned p, rem, shift;
    p     = (64'd8388608 + 64'(a)) * (64'd8388608 + 64'(b));
    inc   = (p >= 64'h0000_8000_0000_0000);
    shift = inc ? 64'd24 : 64'd23;
    mant  = 23'((p >> shift) % 64'd8388608);
    rem   = p % (64'd1 << shift);
    grs[2] = ((rem >> (shift - 1)) & 64'd1) != 0;
    grs[1] = ((rem >> (shift - 2)) & 64'd1) != 0;
    grs[0] = (rem % (64'd1 << (shift - 2))) != 0;
  endfunction

  // Present an operand pair and return after the accept edge
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.in0      = a;
    bus.in1      = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in0      = $urandom;
    bus.in1      = $urandom;
  endtask

  // Wait for out_valid, check latency and result against the model
  task automatic check_result(input string name, input logic [31:0] a, input logic [31:0] b);
    int         lat;
    logic [22:0] e_mant;
    logic        e_inc;
    logic [2:0]  e_grs;
    model(a[22:0], b[22:0], e_mant, e_inc, e_grs);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== EXP_LAT) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d", name, lat, EXP_LAT);
    end
    checks++;
    if ({bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !== {e_mant, e_inc, e_grs}) begin
      failures++;
      $display("FAIL %s_result got mant=%h inc=%b grs=%b required mant=%h inc=%b grs=%b",
               name, bus.out_mantissa, bus.out_exp_inc, bus.out_grs, e_mant, e_inc, e_grs);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy in_ready=%b required=0", name, bus.in_ready);
    end
    $display("op %s a=%h b=%h mant=%h inc=%b grs=%b lat=%0d",
             name, a[22:0], b[22:0], bus.out_mantissa, bus.out_exp_inc, bus.out_grs, lat);
  endtask

  // Consume the result and confirm the block is idle in the next cycle
  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s_return in_ready=%b out_valid=%b required 1/0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b);
    accept(a, b);
    check_result(name, a, b);
    handshake(name);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in0       = '0;
    bus.in1       = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !== {2'b10, 23'd0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b mant=%h inc=%b grs=%b required 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_mantissa, bus.out_exp_inc, bus.out_grs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // out_ready while nothing is valid must not disturb the idle block
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL idle_out_ready in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    run_op("one_x_one",   32'h3F800000, 32'h3F800000);
    run_op("1p5_x_1p5",   32'h3FC00000, 32'h3FC00000);
    run_op("1p5_x_1p25",  32'h3FC00000, 32'h3FA00000);
    run_op("all_ones",    32'h3FFFFFFF, 32'h3FFFFFFF);
    // Explicit spot values for the documented vectors
    accept(32'h3FFFFFFF, 32'h3FFFFFFF);
    check_result("all_ones_again", 32'h3FFFFFFF, 32'h3FFFFFFF);
    checks++;
    if ({bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !== {23'h7FFFFE, 1'b1, 3'b001}) begin
      failures++;
      $display("FAIL all_ones_const got mant=%h inc=%b grs=%b required 7ffffe/1/001",
               bus.out_mantissa, bus.out_exp_inc, bus.out_grs);
    end
    handshake("all_ones_again");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      accept(a, b);
      check_result($sformatf("rand%0d", i), a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      handshake($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [22:0] s_mant;
    logic        s_inc;
    logic [2:0]  s_grs;
    accept(32'h3FC00000, 32'h3FA00000);
    check_result("backpressure", 32'h3FC00000, 32'h3FA00000);
    s_mant = bus.out_mantissa;
    s_inc  = bus.out_exp_inc;
    s_grs  = bus.out_grs;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in0      = 32'h3FFFFFFF;
      bus.in1      = 32'h3FFFFFFF;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !==
          {2'b10, s_mant, s_inc, s_grs}) begin
        failures++;
        $display("FAIL backpressure_hold%0d valid=%b ready=%b mant=%h inc=%b grs=%b required 1/0/%h/%b/%b",
                 i, bus.out_valid, bus.in_ready, bus.out_mantissa, bus.out_exp_inc, bus.out_grs,
                 s_mant, s_inc, s_grs);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !== {23'h700000, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL backpressure_value mant=%h inc=%b grs=%b required 700000/0/000",
               bus.out_mantissa, bus.out_exp_inc, bus.out_grs);
    end
    handshake("backpressure");
  endtask

  task automatic test_back_to_back();
    accept(32'h3F812345, 32'h3FABCDEF);
    check_result("b2b_first", 32'h3F812345, 32'h3FABCDEF);
    // Next operands already waiting while the result is consumed
    bus.in0       = 32'h3FC00000;
    bus.in1       = 32'h3FC00000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_turnaround in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept in_ready=%b required=0", bus.in_ready);
    end
    check_result("b2b_second", 32'h3FC00000, 32'h3FC00000);
    handshake("b2b_second");
  endtask

  task automatic test_reset_mid_calc();
    // Leave a non-zero result in the output registers first
    run_op("pre_reset", 32'h3FFFFFFF, 32'h3FC00000);
    accept(32'h3FFFFFFF, 32'h3FFFFFFF);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_mantissa, bus.out_exp_inc, bus.out_grs} !== {2'b10, 23'd0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL midcalc_reset in_ready=%b out_valid=%b mant=%h inc=%b grs=%b required 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_mantissa, bus.out_exp_inc, bus.out_grs);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL midcalc_idle in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    run_op("post_reset", 32'h3FC00000, 32'h3FC00000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
